// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage assembling 1/2-byte instructions for decode
// Ports: imem_addr/imem_rdata combinational byte-wide instruction memory;
//   valid/ready decode handshake carrying opcode, ra, rb, imm, is_two_byte, pc_next, is_intr;
//   redirect/redirect_pc flush and reload the PC; intr level request, intr_ack injection pulse.
module fetch_unit #(
  parameter int unsigned       ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC_ADDR  = ADDR_W'(1),
  parameter logic [7:0]        INTR_CALL      = 8'hB4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              intr,
  output logic              valid,
  output logic [3:0]        opcode,
  output logic [1:0]        ra,
  output logic [1:0]        rb,
  output logic [7:0]        imm,
  output logic              is_two_byte,
  output logic [ADDR_W-1:0] pc_next,
  output logic              is_intr,
  output logic              intr_ack
);
  typedef enum logic [1:0] {S_VEC, S_OP, S_IMM} state_e;
  state_e            state_q, state_d;
  logic              vec_q, vec_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pcn_q, pcn_d;
  logic              valid_q, valid_d, two_q, two_d, isi_q, isi_d, ack_q, ack_d, pend_q, pend_d;
  logic [7:0]        instr_q, instr_d, imm_q, imm_d, hold_q, hold_d;
  logic              fire, free, two_byte;
  assign fire      = valid_q & ready & ~redirect;
  assign free      = ~valid_q | fire;
  assign two_byte  = (imem_rdata[7:4] == 4'hC) & (imem_rdata[3:2] != 2'b11);
  assign imem_addr = state_q == S_VEC ? (vec_q ? INTR_VEC_ADDR : RESET_VEC_ADDR) : pc_q;
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    pcn_d   = pcn_q;
    two_d   = two_q;
    isi_d   = isi_q;
    ack_d   = 1'b0;
    pend_d  = pend_q | intr;
    hold_d  = hold_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      hold_d  = '0;
      state_d = S_OP;
      // a flushed interrupt CALL never reached decode, so the request must be taken again
      if (valid_q & isi_q) pend_d = 1'b1;
    end else if (state_q == S_VEC) begin
      pc_d    = ADDR_W'(imem_rdata);
      state_d = S_OP;
      if (fire) valid_d = 1'b0;
    end else if (state_q == S_OP) begin
      if (free && pend_q) begin
        instr_d = INTR_CALL;
        imm_d   = '0;
        two_d   = 1'b0;
        isi_d   = 1'b1;
        pcn_d   = pc_q;
        valid_d = 1'b1;
        ack_d   = 1'b1;
        pend_d  = 1'b0;
        vec_d   = 1'b1;
        state_d = S_VEC;
      end else if (free && two_byte) begin
        hold_d  = imem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        valid_d = 1'b0;
        state_d = S_IMM;
      end else if (free) begin
        instr_d = imem_rdata;
        imm_d   = '0;
        two_d   = 1'b0;
        isi_d   = 1'b0;
        pcn_d   = pc_q + ADDR_W'(1);
        pc_d    = pc_q + ADDR_W'(1);
        valid_d = 1'b1;
      end
    end else begin
      instr_d = hold_q;
      imm_d   = imem_rdata;
      two_d   = 1'b1;
      isi_d   = 1'b0;
      pcn_d   = pc_q + ADDR_W'(1);
      pc_d    = pc_q + ADDR_W'(1);
      valid_d = 1'b1;
      state_d = S_OP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_VEC;
      vec_q   <= 1'b0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      imm_q   <= '0;
      pcn_q   <= '0;
      two_q   <= 1'b0;
      isi_q   <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      pcn_q   <= pcn_d;
      two_q   <= two_d;
      isi_q   <= isi_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end
  assign valid       = valid_q;
  assign opcode      = instr_q[7:4];
  assign ra          = instr_q[3:2];
  assign rb          = instr_q[1:0];
  assign imm         = imm_q;
  assign is_two_byte = two_q;
  assign pc_next     = pcn_q;
  assign is_intr     = isi_q;
  assign intr_ack    = ack_q;
endmodule
